lsb_serial_tx: RTL and testbench
================================

// Module: lsb_serial_tx
// PURPOSE
//  Bit-serial transmitter that drives the serial two's-complement converter.
//  - Accepts an N-bit parallel word on a start/ready handshake.
//  - Pulses the converter's clear for one cycle, then emits the word LSB-first,
//    one bit per clock, with valid/last framing.
//  - Signals completion with a one-cycle done pulse.
//  Sits between the parallel datapath and the bit-serial converter; sources all frames.
// PARAMETERS
//  WIDTH  8  bits per word; must be >= 2; bit counter is $clog2(WIDTH) bits
// PORTS
//  clk         in   1      system clock, rising-edge active
//  reset       in   1      asynchronous, active-low reset (0 = reset)
//  start       in   1      request to send data_in; accepted only when ready=1
//  data_in     in   WIDTH  word to transmit; sampled only on the accept edge
//  ready       out  1      1 only in IDLE; start is accepted on any edge where start&ready
//  conv_reset  out  1      active-high clear for the downstream converter; 1 only in CLR
//  bit_out     out  1      current serial bit (shift-register LSB); 0 when bit_valid=0
//  bit_valid   out  1      1 during the WIDTH SHIFT cycles only
//  last        out  1      1 with the final (MSB) bit of a frame
//  done        out  1      one-cycle pulse in the cycle after the last bit
// BEHAVIOUR
//  - Reset (reset=0, any time, async):
//      state=IDLE, shift reg=0, count=0
//      ready=1; conv_reset, bit_out, bit_valid, last, done all 0
//      A frame in progress is aborted immediately: no further bits, no done.
//  - FSM (all outputs decoded from registered state/shift reg/count; no combinational path from inputs):
//      IDLE: ready=1.
//            start=1 at a rising edge -> sreg<=data_in, count<=0, go to CLR.
//            start=0 -> stay in IDLE.
//      CLR:  conv_reset=1, bit_valid=0. Lasts exactly 1 cycle, then go to SHIFT.
//      SHIFT: bit_valid=1, bit_out=sreg[0].
//            Each edge: sreg<=sreg>>1 (zero fill), count<=count+1.
//            last=1 when count==WIDTH-1; the edge after that goes to DONE.
//      DONE: done=1, ready=0. Lasts exactly 1 cycle, then go to IDLE.
//  - Latency: with the accept edge at cycle 0:
//      cycle 1 = CLR; cycles 2..WIDTH+1 = bits 0..WIDTH-1;
//      cycle WIDTH+2 = done; cycle WIDTH+3 = ready again.
//  - start while ready=0 (CLR/SHIFT/DONE): ignored, not queued.
//  - data_in changes after the accept edge: no effect on the current frame.
//  - start held high continuously: next frame accepted on the first IDLE edge;
//    frames are separated by exactly one DONE cycle and one IDLE cycle.
//  - Count never exceeds WIDTH-1; no wrap-around into a new frame without a handshake.
//  - bit_out is forced to 0 outside SHIFT so the converter sees a clean 0 between frames.
// TESTING  (WIDTH=8)
//  1. Assert reset=0 mid-simulation -> ready=1 and all other outputs 0, asynchronously (before the next clk edge).
//  2. data_in=8'hB4, start 1 cycle -> conv_reset=1 for 1 cycle;
//     bit_out=0,0,1,0,1,1,0,1 with bit_valid=1; last on the 8th bit; done 1 cycle later;
//     ready at cycle 11.
//  3. During frame 2: pulse start and change data_in to 8'hFF ->
//     transmitted bits unchanged, no extra frame, exactly one done.
//  4. reset=0 after the 3rd bit -> bit_valid=0 and no done;
//     then release reset, send 8'h01 -> bits 1,0,0,0,0,0,0,0 with correct framing.
//  5. start held high for 3 frames of 8'h5A -> 3 done pulses;
//     accepts exactly WIDTH+3=11 cycles apart; no bit gaps inside a frame.
//  6. Loopback into the converter, send 8'h05 -> converter output is
//     1,1,0,1,1,1,1,1 (8'hFB); then send 8'h80 -> converter output is 8'h80.

Source files
------------

// File: rtl/lsb_serial_tx_if.sv
// Parallel-side handshake and bit-serial output bundle of the LSB-first transmitter.
// The master drives start/data_in; the slave (the transmitter) drives the framing.
`timescale 1ns/1ps
interface lsb_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             conv_reset;
  logic             bit_out;
  logic             bit_valid;
  logic             last;
  logic             done;

  modport master (
    output start, data_in,
    input  ready, conv_reset, bit_out, bit_valid, last, done
  );

  modport slave (
    input  start, data_in,
    output ready, conv_reset, bit_out, bit_valid, last, done
  );
endinterface

// File: rtl/lsb_serial_tx.sv
// Bit-serial transmitter: clears the downstream converter for one cycle, then
// sends a WIDTH-bit word LSB-first with valid/last framing and a done pulse.
`timescale 1ns/1ps
module lsb_serial_tx #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  lsb_serial_tx_if.slave bus
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q, ready_d;
  logic             conv_reset_q, conv_reset_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sreg_d  = bus.data_in;
          count_d = '0;
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        sreg_d = sreg_q >> 1;
        if (count_q == LAST_CNT) begin
          count_d = '0;
          state_d = ST_DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops aligned with it.
  always_comb begin
    ready_d      = (state_d == ST_IDLE);
    conv_reset_d = (state_d == ST_CLR);
    bit_valid_d  = (state_d == ST_SHIFT);
    bit_out_d    = (state_d == ST_SHIFT) && sreg_d[0];
    last_d       = (state_d == ST_SHIFT) && (count_d == LAST_CNT);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      count_q      <= '0;
      ready_q      <= 1'b1;
      conv_reset_q <= 1'b0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      count_q      <= count_d;
      ready_q      <= ready_d;
      conv_reset_q <= conv_reset_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      last_q       <= last_d;
      done_q       <= done_d;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.conv_reset = conv_reset_q;
  assign bus.bit_out    = bit_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.last       = last_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_lsb_serial_tx.sv
// Bench for lsb_serial_tx: frames are captured cycle by cycle and compared with
// the frame schedule and bit order derived from the word, plus a converter model.
`timescale 1ns/1ps
module tb_lsb_serial_tx;
  localparam int WIDTH = 8;
  localparam int NCYC  = WIDTH + 3;
  localparam logic [5:0] IDLE_OBS = 6'b100000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   check_count = 0;
  int   pass_count = 0;
  int   cycle_no = 0;
  int   frame_start = 0;

  // Observation layout: {ready, conv_reset, bit_valid, bit_out, last, done}
  logic [5:0] obs [1:NCYC];

  lsb_serial_tx_if #(.WIDTH(WIDTH)) bus ();

  lsb_serial_tx #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_no++;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [5:0] sample();
    return {bus.ready, bus.conv_reset, bus.bit_valid, bus.bit_out, bus.last, bus.done};
  endfunction

  // Frame schedule with the accept edge closing cycle 0.
  function automatic logic [5:0] expect_obs(input logic [WIDTH-1:0] w, input int k);
    logic rdy, clr, vld, b, lst, dn;
    int   idx;
    idx = k - 2;
    vld = (idx >= 0) && (idx < WIDTH);
    b   = vld && w[idx];
    rdy = (k >= WIDTH + 3);
    clr = (k == 1);
    lst = (idx == WIDTH - 1);
    dn  = (k == WIDTH + 2);
    return {rdy, clr, vld, b, lst, dn};
  endfunction

  // Collects one frame; optionally holds start and pokes start/data mid-frame.
  task automatic run_frame(input logic [WIDTH-1:0] w, input bit hold,
                           input int poke_cycle, input logic [WIDTH-1:0] poke_data);
    bus.start   = 1'b1;
    bus.data_in = w;
    for (int k = 1; k <= NCYC; k++) begin
      @(negedge clk);
      obs[k] = sample();
      if (k == 1) begin
        frame_start = cycle_no;
        if (!hold) bus.start = 1'b0;
        bus.data_in = WIDTH'($urandom);
      end
      if (k == poke_cycle) begin
        bus.start   = 1'b1;
        bus.data_in = poke_data;
      end else if (k == poke_cycle + 1 && !hold) begin
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] w;
    repeat (3) @(negedge clk);
    check_count++;
    if (sample() !== IDLE_OBS) $display("[TB] FAIL reset_state: got %b expected %b", sample(), IDLE_OBS);
    else pass_count++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_count++;
    if (sample() !== IDLE_OBS) $display("[TB] FAIL idle_after_release: got %b expected %b", sample(), IDLE_OBS);
    else pass_count++;
    w = WIDTH'($urandom);
    bus.start   = 1'b1;
    bus.data_in = w;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_count++;
    if (bus.bit_valid !== 1'b1) $display("[TB] FAIL midframe_valid: got %b expected 1", bus.bit_valid);
    else pass_count++;
    #2 reset = 1'b0;
    #1;
    check_count++;
    if (sample() !== IDLE_OBS) $display("[TB] FAIL async_reset: got %b expected %b", sample(), IDLE_OBS);
    else pass_count++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame();
    logic [WIDTH-1:0] w;
    for (int f = 0; f < 6; f++) begin
      w = (f == 0) ? WIDTH'(8'hB4) : WIDTH'($urandom);
      run_frame(w, 1'b0, 0, '0);
      for (int k = 1; k <= NCYC; k++) begin
        check_count++;
        if (obs[k] !== expect_obs(w, k))
          $display("[TB] FAIL frame_%02h cycle %0d: got %b expected %b", w, k, obs[k], expect_obs(w, k));
        else pass_count++;
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [WIDTH-1:0] w;
    int pulses;
    for (int p = 0; p < 2; p++) begin
      w = WIDTH'($urandom);
      run_frame(w, 1'b0, (p == 0) ? 4 : WIDTH + 2, WIDTH'(8'hFF));
      for (int k = 1; k <= NCYC; k++) begin
        check_count++;
        if (obs[k] !== expect_obs(w, k))
          $display("[TB] FAIL ignore_%0d cycle %0d: got %b expected %b", p, k, obs[k], expect_obs(w, k));
        else pass_count++;
      end
      pulses = 0;
      for (int k = 0; k < NCYC; k++) begin
        @(negedge clk);
        if (sample() !== IDLE_OBS) pulses++;
      end
      check_count++;
      if (pulses !== 0) $display("[TB] FAIL no_extra_frame_%0d: got %0d busy cycles expected 0", p, pulses);
      else pass_count++;
    end
  endtask

  task automatic test_abort();
    logic [WIDTH-1:0] w;
    int busy;
    w = WIDTH'($urandom);
    bus.start   = 1'b1;
    bus.data_in = w;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_count++;
    if (sample() !== expect_obs(w, 4)) $display("[TB] FAIL abort_third_bit: got %b expected %b", sample(), expect_obs(w, 4));
    else pass_count++;
    #2 reset = 1'b0;
    busy = 0;
    for (int k = 0; k < NCYC; k++) begin
      @(negedge clk);
      if (sample() !== IDLE_OBS) busy++;
    end
    check_count++;
    if (busy !== 0) $display("[TB] FAIL abort_quiet: got %0d busy cycles expected 0", busy);
    else pass_count++;
    reset = 1'b1;
    @(negedge clk);
    run_frame(WIDTH'(8'h01), 1'b0, 0, '0);
    for (int k = 1; k <= NCYC; k++) begin
      check_count++;
      if (obs[k] !== expect_obs(WIDTH'(8'h01), k))
        $display("[TB] FAIL after_abort cycle %0d: got %b expected %b", k, obs[k], expect_obs(WIDTH'(8'h01), k));
      else pass_count++;
    end
  endtask

  task automatic test_back_to_back();
    int starts [3];
    for (int f = 0; f < 3; f++) begin
      run_frame(WIDTH'(8'h5A), 1'b1, 0, '0);
      starts[f] = frame_start;
      for (int k = 1; k <= NCYC; k++) begin
        check_count++;
        if (obs[k] !== expect_obs(WIDTH'(8'h5A), k))
          $display("[TB] FAIL b2b_%0d cycle %0d: got %b expected %b", f, k, obs[k], expect_obs(WIDTH'(8'h5A), k));
        else pass_count++;
      end
    end
    bus.start = 1'b0;
    for (int f = 1; f < 3; f++) begin
      check_count++;
      if (starts[f] - starts[f-1] !== NCYC)
        $display("[TB] FAIL b2b_spacing_%0d: got %0d expected %0d", f, starts[f] - starts[f-1], NCYC);
      else pass_count++;
    end
    repeat (2) @(negedge clk);
    check_count++;
    if (sample() !== IDLE_OBS) $display("[TB] FAIL b2b_stop: got %b expected %b", sample(), IDLE_OBS);
    else pass_count++;
  endtask

  // Converter model: pass bits up to and including the first 1, invert afterwards.
  task automatic test_loopback();
    logic [WIDTH-1:0] w, conv, want;
    logic seen, b;
    int idx;
    for (int f = 0; f < 4; f++) begin
      w = (f == 0) ? WIDTH'(8'h05) : (f == 1) ? WIDTH'(8'h80) : WIDTH'($urandom);
      want = (f == 0) ? WIDTH'(8'hFB) : (f == 1) ? WIDTH'(8'h80) : WIDTH'(-w);
      run_frame(w, 1'b0, 0, '0);
      conv = '1;
      seen = 1'b0;
      idx  = 0;
      for (int k = 1; k <= NCYC; k++) begin
        if (obs[k][4]) begin
          seen = 1'b0;
          idx  = 0;
        end else if (obs[k][3] && idx < WIDTH) begin
          b = obs[k][2];
          conv[idx] = seen ? ~b : b;
          seen = seen | b;
          idx++;
        end
      end
      check_count++;
      if (conv !== want) $display("[TB] FAIL loopback_%02h: got %02h expected %02h", w, conv, want);
      else pass_count++;
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.data_in = '0;
    reset       = 1'b0;
    test_reset();
    test_frame();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_loopback();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
